// File: rtl/irq_ctrl7.sv
// Seven-line interrupt front-end: pending capture, masking, lowest-number-wins
// selection and an irq/ack/eoi handshake. Optional macro IRQ_SYNC_EN adds a 2-flop req synchronizer.
module irq_ctrl7 #(
  parameter logic [7:1] MASK_RST = 7'h00,
  parameter bit         EDGE     = 1'b1
) (
  input  logic       c,
  input  logic       r,
  input  logic [7:1] req,
  input  logic       mw,
  input  logic [7:1] md,
  input  logic       ack,
  input  logic       eoi,
  output logic       irq,
  output logic [2:0] vec,
  output logic [7:1] pm,
  output logic       busy
);

  typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_SERV} state_t;

  state_t     state;
  logic [7:1] req_s;
  logic [7:1] hist;
  logic [7:1] pend;
  logic [7:1] mask;
  logic [7:1] pend_next;
  logic [7:1] vec_onehot;
  logic [7:1] clr;
  logic [2:0] win;
  logic [1:0] warm_cnt;
  logic       armed;

`ifdef IRQ_SYNC_EN
  localparam logic [1:0] WARM = 2'd3;
  logic [7:1] sync1;
  logic [7:1] sync2;

  always_ff @(posedge c or negedge r) begin
    if (!r) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= req;
      sync2 <= sync1;
    end
  end
  assign req_s = sync2;
`else
  localparam logic [1:0] WARM = 2'd1;
  assign req_s = req;
`endif

  // A line already high when reset is released is not an edge: edge detection
  // stays off until the history register holds a real sample of req.
  assign armed = (warm_cnt == WARM);

  always_ff @(posedge c or negedge r) begin
    if (!r)
      warm_cnt <= '0;
    else if (!armed)
      warm_cnt <= warm_cnt + 2'd1;
  end

  assign pm = pend & ~mask;

  always_comb begin
    win = 3'd0;
    for (int i = 7; i >= 1; i--)
      if (pm[i]) win = 3'(i);
  end

  always_comb begin
    vec_onehot = '0;
    for (int i = 1; i <= 7; i++)
      vec_onehot[i] = (vec == 3'(i));
  end

  assign clr = (state == S_ASSERT && ack) ? vec_onehot : '0;

  // Set is applied after clear so a fresh edge in the ack cycle survives.
  always_comb begin
    if (EDGE)
      pend_next = (pend & ~clr) | (req_s & ~hist & {7{armed}});
    else
      pend_next = req_s;
  end

  always_ff @(posedge c or negedge r) begin
    if (!r) begin
      pend <= '0;
      hist <= '0;
      mask <= MASK_RST;
    end else begin
      pend <= pend_next;
      hist <= req_s;
      if (mw) mask <= md;
    end
  end

  always_ff @(posedge c or negedge r) begin
    if (!r) begin
      state <= S_IDLE;
      irq   <= 1'b0;
      vec   <= 3'd0;
      busy  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pm != '0) begin
            state <= S_ASSERT;
            irq   <= 1'b1;
            vec   <= win;
          end
        end
        S_ASSERT: begin
          if (ack) begin
            state <= S_SERV;
            irq   <= 1'b0;
            busy  <= 1'b1;
          end
        end
        S_SERV: begin
          if (eoi) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            vec   <= 3'd0;
          end
        end
        default: begin
          state <= S_IDLE;
          irq   <= 1'b0;
          vec   <= 3'd0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl7.sv
// Directed-vector bench for irq_ctrl7: one table row per clock cycle, plus
// hand-written sequences for reset-in-service and the synchronizer build.
module tb_irq_ctrl7;

  logic       c;
  logic       r;
  logic [7:1] req;
  logic       mw;
  logic [7:1] md;
  logic       ack;
  logic       eoi;
  logic       irq;
  logic [2:0] vec;
  logic [7:1] pm;
  logic       busy;

  int n_applied = 0;
  int n_miss    = 0;

  irq_ctrl7 dut (
    .c(c), .r(r), .req(req), .mw(mw), .md(md), .ack(ack), .eoi(eoi),
    .irq(irq), .vec(vec), .pm(pm), .busy(busy)
  );

  initial c = 1'b0;
  always #5 c = ~c;

  typedef struct {
    logic       r;
    logic [7:1] req;
    logic       mw;
    logic [7:1] md;
    logic       ack;
    logic       eoi;
    logic       irq;
    logic [2:0] vec;
    logic [7:1] pm;
    logic       busy;
  } vec_t;

  vec_t tv[64];
  int   n_tv = 0;

  task automatic add(input logic r_i, input logic [7:1] req_i, input logic mw_i,
                     input logic [7:1] md_i, input logic ack_i, input logic eoi_i,
                     input logic irq_e, input logic [2:0] vec_e,
                     input logic [7:1] pm_e, input logic busy_e);
    tv[n_tv] = '{r_i, req_i, mw_i, md_i, ack_i, eoi_i, irq_e, vec_e, pm_e, busy_e};
    n_tv++;
  endtask

  task automatic check(input string name, input logic e_irq, input logic [2:0] e_vec,
                       input logic [7:1] e_pm, input logic e_busy);
    n_applied++;
    if ({irq, vec, pm, busy} !== {e_irq, e_vec, e_pm, e_busy}) begin
      n_miss++;
      $display("FAIL %s: got irq=%b vec=%0d pm=%h busy=%b, want irq=%b vec=%0d pm=%h busy=%b",
               name, irq, vec, pm, busy, e_irq, e_vec, e_pm, e_busy);
    end else begin
      $display("%s: irq=%b vec=%0d pm=%h busy=%b ok", name, irq, vec, pm, busy);
    end
  endtask

  initial begin
    r = 1'b0; req = 7'h7F; mw = 1'b0; md = 7'h00; ack = 1'b0; eoi = 1'b0;
    #1;
    check("reset_async", 1'b0, 3'd0, 7'h00, 1'b0);

`ifndef IRQ_SYNC_EN
    //   r  req    mw md     ack eoi   irq vec pm     busy
    add(0, 7'h7F, 0, 7'h00, 0, 0,     0, 0, 7'h00, 0);
    add(1, 7'h7F, 0, 7'h00, 0, 0,     0, 0, 7'h00, 0);  // req high out of reset: no edge
    add(1, 7'h7F, 0, 7'h00, 0, 0,     0, 0, 7'h00, 0);
    add(1, 7'h00, 0, 7'h00, 0, 0,     0, 0, 7'h00, 0);
    add(1, 7'h00, 0, 7'h00, 0, 0,     0, 0, 7'h00, 0);
    add(1, 7'h04, 0, 7'h00, 0, 0,     0, 0, 7'h04, 0);  // single request line 3
    add(1, 7'h04, 0, 7'h00, 0, 0,     1, 3, 7'h04, 0);
    add(1, 7'h04, 0, 7'h00, 1, 0,     0, 3, 7'h00, 1);
    add(1, 7'h00, 0, 7'h00, 0, 0,     0, 3, 7'h00, 1);
    add(1, 7'h00, 0, 7'h00, 0, 1,     0, 0, 7'h00, 0);
    add(1, 7'h00, 0, 7'h00, 0, 0,     0, 0, 7'h00, 0);
    add(1, 7'h22, 0, 7'h00, 0, 0,     0, 0, 7'h22, 0);  // lines 6 and 2 together
    add(1, 7'h22, 0, 7'h00, 0, 0,     1, 2, 7'h22, 0);
    add(1, 7'h22, 0, 7'h00, 1, 0,     0, 2, 7'h20, 1);
    add(1, 7'h22, 0, 7'h00, 0, 1,     0, 0, 7'h20, 0);
    add(1, 7'h22, 0, 7'h00, 0, 0,     1, 6, 7'h20, 0);
    add(1, 7'h00, 0, 7'h00, 1, 0,     0, 6, 7'h00, 1);
    add(1, 7'h00, 0, 7'h00, 0, 1,     0, 0, 7'h00, 0);
    add(1, 7'h00, 1, 7'h04, 0, 0,     0, 0, 7'h00, 0);  // mask line 3
    add(1, 7'h04, 0, 7'h00, 0, 0,     0, 0, 7'h00, 0);
    add(1, 7'h04, 0, 7'h00, 0, 0,     0, 0, 7'h00, 0);
    add(1, 7'h00, 1, 7'h00, 0, 0,     0, 0, 7'h04, 0);  // unmask: retained pending shows
    add(1, 7'h00, 0, 7'h00, 0, 0,     1, 3, 7'h04, 0);
    add(1, 7'h00, 0, 7'h00, 1, 0,     0, 3, 7'h00, 1);
    add(1, 7'h00, 0, 7'h00, 0, 1,     0, 0, 7'h00, 0);
    add(1, 7'h04, 0, 7'h00, 0, 0,     0, 0, 7'h04, 0);
    add(1, 7'h00, 0, 7'h00, 0, 0,     1, 3, 7'h04, 0);
    add(1, 7'h04, 0, 7'h00, 1, 0,     0, 3, 7'h04, 1);  // new edge with ack: set wins
    add(1, 7'h04, 0, 7'h00, 0, 0,     0, 3, 7'h04, 1);
    add(1, 7'h00, 0, 7'h00, 0, 1,     0, 0, 7'h04, 0);
    add(1, 7'h00, 0, 7'h00, 0, 0,     1, 3, 7'h04, 0);
    add(1, 7'h00, 0, 7'h00, 1, 0,     0, 3, 7'h00, 1);
    add(1, 7'h00, 0, 7'h00, 1, 0,     0, 3, 7'h00, 1);  // ack in SERV ignored
    add(1, 7'h00, 0, 7'h00, 1, 1,     0, 0, 7'h00, 0);  // ack+eoi in SERV: eoi acts
    add(1, 7'h00, 0, 7'h00, 0, 1,     0, 0, 7'h00, 0);  // eoi in IDLE ignored
    add(1, 7'h11, 0, 7'h00, 0, 0,     0, 0, 7'h11, 0);
    add(1, 7'h11, 0, 7'h00, 0, 0,     1, 1, 7'h11, 0);
    add(1, 7'h11, 0, 7'h00, 1, 0,     0, 1, 7'h10, 1);

    for (int i = 0; i < n_tv; i++) begin
      @(negedge c);
      r = tv[i].r; req = tv[i].req; mw = tv[i].mw; md = tv[i].md;
      ack = tv[i].ack; eoi = tv[i].eoi;
      @(posedge c);
      #1;
      check($sformatf("v%0d", i), tv[i].irq, tv[i].vec, tv[i].pm, tv[i].busy);
    end
`else
    repeat (3) @(negedge c);
    r = 1'b1; req = 7'h00;
    repeat (6) @(negedge c);
    req = 7'h01;
    begin
      int k;
      k = 0;
      for (int j = 1; j <= 10; j++) begin
        @(posedge c);
        #1;
        if (irq && k == 0) k = j;
      end
      n_applied++;
      if (k != 4) begin
        n_miss++;
        $display("FAIL sync_latency: got %0d cycles, want 4", k);
      end else begin
        $display("sync_latency: %0d cycles ok", k);
      end
    end
    check("sync_assert", 1'b1, 3'd1, 7'h01, 1'b0);
    @(negedge c); ack = 1'b1;
    @(posedge c); #1;
    check("sync_ack", 1'b0, 3'd1, 7'h00, 1'b1);
    @(negedge c); ack = 1'b0; eoi = 1'b1;
    @(posedge c); #1;
    check("sync_eoi", 1'b0, 3'd0, 7'h00, 1'b0);
    @(negedge c); eoi = 1'b0;
    // Put a pending line into service before the mid-operation reset.
    req = 7'h10;
    repeat (6) @(posedge c);
    @(negedge c); ack = 1'b1;
    @(posedge c); #1;
    check("sync_ack5", 1'b0, 3'd5, 7'h00, 1'b1);
    @(negedge c); ack = 1'b0; req = 7'h00;
`endif

    // Reset pulsed while a line is in service takes effect without a clock edge.
    @(negedge c);
    r = 1'b0; req = 7'h00; ack = 1'b0; eoi = 1'b0; mw = 1'b0;
    #1;
    check("reset_in_serv", 1'b0, 3'd0, 7'h00, 1'b0);
    @(negedge c);
    r = 1'b1;
    repeat (4) @(posedge c);
    #1;
    check("after_reset_idle", 1'b0, 3'd0, 7'h00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within 100000 time units");
    $fatal(1);
  end

endmodule
